// File: rtl/ion_framer_pkg.sv
// ---------------------------------------------------------------------------
// ion_framer_pkg
// Shared definitions for the ion sensor framer: FSM state encoding, packet
// and frame geometry, default header byte, and helpers that slice a packet
// into frame data bytes and compute the frame checksum.
// ---------------------------------------------------------------------------
package ion_framer_pkg;

   localparam int unsigned PKT_W            = 110;
   localparam int unsigned FRAME_DATA_BYTES = 14;
   localparam int unsigned PADDED_W         = 8 * FRAME_DATA_BYTES;  // 112
   localparam logic [7:0]  DEFAULT_HEADER   = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HEADER   = 2'd1,
      ST_DATA     = 2'd2,
      ST_CHECKSUM = 2'd3
   } state_t;

   // Data byte k of a frame: the packet zero-extended to 112 bits and read
   // MSB first, so byte 0 carries the two pad bits plus packet bits 109:104.
   function automatic logic [7:0] frame_byte(input logic [PKT_W-1:0] pkt,
                                             input logic [3:0]       k);
      logic [PADDED_W-1:0] padded;
      padded = {{(PADDED_W - PKT_W){1'b0}}, pkt};
      return padded[(PADDED_W - 1 - 8 * int'(k)) -: 8];
   endfunction

   // XOR of the 14 data bytes; the header byte is not covered.
   function automatic logic [7:0] frame_checksum(input logic [PKT_W-1:0] pkt);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < int'(FRAME_DATA_BYTES); k++) begin
         acc = acc ^ frame_byte(pkt, 4'(k));
      end
      return acc;
   endfunction

endpackage

// File: rtl/ion_framer_pkt_fifo2.sv
// ---------------------------------------------------------------------------
// pkt_fifo2
// Two-entry synchronous FIFO holding whole sensor packets.
//   clock    : system clock, rising edge
//   resetn   : asynchronous active-low reset (empties the FIFO)
//   wr_en    : write request; accepted when not full, or when full and a
//              read happens on the same edge
//   wr_data  : packet to write
//   rd_en    : pop the head entry
//   rd_data  : head entry (valid while empty = 0)
//   full     : both entries occupied
//   empty    : no entries occupied
// ---------------------------------------------------------------------------
module pkt_fifo2
   import ion_framer_pkg::*;
(
   input  logic             clock,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [PKT_W-1:0] wr_data,
   input  logic             rd_en,
   output logic [PKT_W-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [PKT_W-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   assign pop   = rd_en && !empty;
   // When full, the write slot is the head slot; it is only overwritten on
   // the edge that pops the head, so a frame in flight never sees it change.
   assign push  = wr_en && (!full || pop);

   assign rd_data = mem[rd_ptr];

   // NOTE: packet storage has no reset; the pointers and count already mark
   // every entry invalid, so clearing 220 data flops would buy nothing.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ion_framer.sv
// ---------------------------------------------------------------------------
// ion_framer
// Buffers 110-bit sensor packets in a 2-entry FIFO and serialises each one
// as a 16-byte frame: header byte, 14 data bytes (MSB first), XOR checksum.
//   clock       : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   ready_in    : packet strobe, only bit 0 is used
//   data_in     : sensor packet, sampled when ready_in[0] = 1
//   byte_out    : current frame byte (8'h00 while byte_valid = 0)
//   byte_valid  : byte_out holds a frame byte
//   byte_ready  : transmitter accepts byte_out this cycle
//   busy        : frame in progress or packets waiting
//   overflow    : sticky, a packet was dropped on a full FIFO
//   frames_sent : completed frame count, wraps at 16 bits
// ---------------------------------------------------------------------------
module ion_framer
   import ion_framer_pkg::*;
#(
   parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [7:0]       ready_in,
   input  logic [PKT_W-1:0] data_in,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             busy,
   output logic             overflow,
   output logic [15:0]      frames_sent
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_DATA_BYTES - 1);

   state_t           state;
   logic [3:0]       idx;
   logic [PKT_W-1:0] head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             drop;
   logic             unused_strobe_bits;

   // Upper strobe bits carry no meaning for this block.
   assign unused_strobe_bits = ^ready_in[7:1];

   // The head is released on the checksum transfer, the same edge that
   // completes the frame.
   assign pop  = (state == ST_CHECKSUM) && byte_ready;
   assign drop = ready_in[0] && fifo_full && !pop;
   assign busy = (state != ST_IDLE) || !fifo_empty;

   pkt_fifo2 u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .wr_en   (ready_in[0]),
      .wr_data (data_in),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Outputs are registered alongside the state, so byte_out/byte_valid hold
   // steady whenever the transmitter stalls.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         idx         <= 4'd0;
         byte_out    <= 8'h00;
         byte_valid  <= 1'b0;
         frames_sent <= 16'h0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state      <= ST_HEADER;
                  byte_valid <= 1'b1;
                  byte_out   <= HEADER_BYTE;
               end
            end
            ST_HEADER: begin
               if (byte_ready) begin
                  state    <= ST_DATA;
                  idx      <= 4'd0;
                  byte_out <= frame_byte(head, 4'd0);
               end
            end
            ST_DATA: begin
               if (byte_ready) begin
                  if (idx == LAST_IDX) begin
                     state    <= ST_CHECKSUM;
                     byte_out <= frame_checksum(head);
                  end else begin
                     idx      <= idx + 4'd1;
                     byte_out <= frame_byte(head, idx + 4'd1);
                  end
               end
            end
            ST_CHECKSUM: begin
               if (byte_ready) begin
                  // Returning through IDLE guarantees a gap cycle between frames.
                  state       <= ST_IDLE;
                  idx         <= 4'd0;
                  byte_valid  <= 1'b0;
                  byte_out    <= 8'h00;
                  frames_sent <= frames_sent + 16'd1;
               end
            end
            default: begin
               state      <= ST_IDLE;
               byte_valid <= 1'b0;
               byte_out   <= 8'h00;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ion_framer.sv
// ---------------------------------------------------------------------------
// tb_ion_framer
// Directed bench for ion_framer. Expected frame bytes are queued when a
// packet is offered and popped as the DUT transfers bytes.
// ---------------------------------------------------------------------------
module tb_ion_framer;

   localparam int PW = 110;

   typedef struct packed {
      logic [7:0] b;
      logic       last;
   } exp_t;

   logic          clock = 1'b0;
   logic          resetn;
   logic [7:0]    ready_in;
   logic [PW-1:0] data_in;
   logic [7:0]    byte_out;
   logic          byte_valid;
   logic          byte_ready;
   logic          busy;
   logic          overflow;
   logic [15:0]   frames_sent;

   int   tests  = 0;
   int   failed = 0;
   int   xfers  = 0;
   exp_t sb[$];

   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [7:0] prev_byte  = 8'h00;
   logic       expect_gap = 1'b0;
   logic       last_pop   = 1'b0;

   ion_framer dut (
      .clock       (clock),
      .resetn      (resetn),
      .ready_in    (ready_in),
      .data_in     (data_in),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .busy        (busy),
      .overflow    (overflow),
      .frames_sent (frames_sent)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past a rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference frame: shift the padded packet out top byte first.
   function automatic void push_frame(input logic [PW-1:0] p);
      logic [111:0] w;
      logic [7:0]   cs;
      w  = {2'b00, p};
      cs = 8'h00;
      sb.push_back('{b: 8'hA5, last: 1'b0});
      for (int k = 0; k < 14; k++) begin
         sb.push_back('{b: w[111:104], last: 1'b0});
         cs = cs ^ w[111:104];
         w  = w << 8;
      end
      sb.push_back('{b: cs, last: 1'b1});
   endfunction

   // Per-cycle output checks; byte_ready for the cycle must already be driven.
   task automatic observe();
      exp_t e;
      if (expect_gap) begin
         check("idle_gap", 32'(byte_valid), 32'd0);
         expect_gap = 1'b0;
      end
      if (prev_valid && !prev_ready) begin
         check("hold_valid", 32'(byte_valid), 32'd1);
         check("hold_byte", 32'(byte_out), 32'(prev_byte));
      end
      if (!byte_valid) begin
         check("zero_when_idle", 32'(byte_out), 32'd0);
      end else if (byte_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_byte", 32'(byte_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("frame_byte", 32'(byte_out), 32'(e.b));
            xfers++;
            if (e.last) begin
               expect_gap = 1'b1;
               last_pop   = 1'b1;
            end
         end
      end
      prev_valid = byte_valid;
      prev_ready = byte_ready;
      prev_byte  = byte_out;
   endtask

   // Offer a packet for one cycle; upper strobe bits carry random junk.
   task automatic send(input logic [PW-1:0] p, input bit accept);
      ready_in = {7'($urandom), 1'b1};
      data_in  = p;
      if (accept) push_frame(p);
      observe();
      tick();
      ready_in = {7'($urandom), 1'b0};
   endtask

   // Drain queued frames. mode 0: byte_ready always 1; mode 1: toggles 1/0.
   // With inject set, a packet is offered on the cycle of the first head pop.
   task automatic run(input int mode, input bit inject, input logic [PW-1:0] inj);
      int n;
      bit injected;
      n        = 0;
      injected = 1'b0;
      last_pop = 1'b0;
      while (sb.size() != 0 || busy) begin
         byte_ready = (mode == 0) ? 1'b1 : (n % 2 == 0);
         observe();
         if (inject && last_pop && !injected) begin
            ready_in[0] = 1'b1;
            data_in     = inj;
            push_frame(inj);
            injected    = 1'b1;
            tick();
            check("no_ovf_on_pop", 32'(overflow), 32'd0);
         end else begin
            tick();
         end
         ready_in[0] = 1'b0;
         n++;
         if (n > 2000) begin
            check("run_timeout", 32'(n), 32'd0);
            break;
         end
      end
   endtask

   function automatic logic [PW-1:0] rand_pkt();
      return {14'($urandom), $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [PW-1:0] ones;
      logic [PW-1:0] pa, pb, pc;
      int start;
      ones = '1;

      // Reset state
      resetn     = 1'b0;
      ready_in   = 8'h00;
      data_in    = '0;
      byte_ready = 1'b0;
      #1;
      check("rst_valid", 32'(byte_valid), 32'd0);
      check("rst_byte", 32'(byte_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_frames", 32'(frames_sent), 32'd0);
      tick();
      tick();
      resetn = 1'b1;
      tick();

      // All-zero packet with latency check: strobe in cycle N, header in N+2
      byte_ready = 1'b1;
      send('0, 1'b1);
      check("lat_n1_valid", 32'(byte_valid), 32'd0);
      check("lat_n1_busy", 32'(busy), 32'd1);
      observe();
      tick();
      check("lat_n2_valid", 32'(byte_valid), 32'd1);
      check("lat_n2_byte", 32'(byte_out), 32'hA5);
      run(0, 1'b0, '0);
      check("frames_after_zero", 32'(frames_sent), 32'd1);

      // Packet value 1: last data byte and checksum both 01
      send(110'h1, 1'b1);
      run(0, 1'b0, '0);
      check("frames_after_one", 32'(frames_sent), 32'd2);

      // All ones with stalling transmitter; expected bytes written out directly
      sb.push_back('{b: 8'hA5, last: 1'b0});
      sb.push_back('{b: 8'h3F, last: 1'b0});
      for (int k = 0; k < 13; k++) sb.push_back('{b: 8'hFF, last: 1'b0});
      sb.push_back('{b: 8'hC0, last: 1'b1});
      ready_in = 8'h01;
      data_in  = ones;
      observe();
      tick();
      ready_in = 8'h00;
      run(1, 1'b0, '0);
      check("frames_after_ones", 32'(frames_sent), 32'd3);

      // Fill FIFO while stalled, then offer a packet on the pop edge
      pa = rand_pkt();
      pb = rand_pkt();
      pc = rand_pkt();
      byte_ready = 1'b0;
      send(pa, 1'b1);
      send(pb, 1'b1);
      check("full_no_ovf", 32'(overflow), 32'd0);
      run(0, 1'b1, pc);
      check("frames_after_inject", 32'(frames_sent), 32'd6);
      check("ovf_still_clear", 32'(overflow), 32'd0);

      // Three strobes while stalled: two buffered, third dropped
      pa = rand_pkt();
      pb = rand_pkt();
      pc = rand_pkt();
      byte_ready = 1'b0;
      send(pa, 1'b1);
      send(pb, 1'b1);
      check("two_buffered_ovf", 32'(overflow), 32'd0);
      send(pc, 1'b0);
      check("drop_sets_ovf", 32'(overflow), 32'd1);
      run(0, 1'b0, '0);
      check("frames_after_drop", 32'(frames_sent), 32'd8);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Reset after the fifth data byte is transferred
      byte_ready = 1'b1;
      start = xfers;
      send(rand_pkt(), 1'b1);
      for (int i = 0; i < 50 && (xfers - start) < 6; i++) begin
         observe();
         tick();
      end
      check("reset_point_xfers", 32'(xfers - start), 32'd6);
      resetn = 1'b0;
      #1;
      check("midrst_valid", 32'(byte_valid), 32'd0);
      check("midrst_byte", 32'(byte_out), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_frames", 32'(frames_sent), 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      sb.delete();
      prev_valid = 1'b0;
      expect_gap = 1'b0;
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_quiet", 32'(byte_valid), 32'd0);
      end
      send(rand_pkt(), 1'b1);
      run(0, 1'b0, '0);
      check("frames_after_rst", 32'(frames_sent), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
